// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with synchroniser, glitch rejection, parity/framing flags and break handling
module uart_rx_param #(
    parameter int BITDUR     = 1736,
    parameter int DATABITS   = 8,
    parameter int PARITY     = 0,
    parameter int STOPBITS   = 1,
    parameter int SYNCSTAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in,
    output logic [DATABITS-1:0] data,
    output logic                ready,
    output logic                parityErr,
    output logic                frameErr,
    output logic                busy
);
    localparam int CW = $clog2(BITDUR);
    localparam int IW = $clog2(DATABITS + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
    state_t state, state_n;
    logic [SYNCSTAGES-1:0] sync;
    logic sync_in, mid;
    logic [CW-1:0] ctr, ctr_n;
    logic [IW-1:0] idx, idx_n;
    logic [DATABITS-1:0] shift, shift_n, data_n;
    logic par_bit, par_n, ferr, ferr_n, ready_n, pe_n, fe_n;
    assign sync_in = sync[SYNCSTAGES-1];
    assign mid = ctr == CW'(BITDUR - 1);
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '1;
            state     <= IDLE;
            ctr       <= '0;
            idx       <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            ferr      <= 1'b0;
            data      <= '0;
            ready     <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            sync      <= {sync[SYNCSTAGES-2:0], in};
            state     <= state_n;
            ctr       <= ctr_n;
            idx       <= idx_n;
            shift     <= shift_n;
            par_bit   <= par_n;
            ferr      <= ferr_n;
            data      <= data_n;
            ready     <= ready_n;
            parityErr <= pe_n;
            frameErr  <= fe_n;
        end
    end
    always_comb begin
        state_n = state;
        ctr_n   = mid ? '0 : ctr + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        par_n   = par_bit;
        ferr_n  = ferr;
        data_n  = data;
        pe_n    = parityErr;
        fe_n    = frameErr;
        ready_n = 1'b0;
        case (state)
            IDLE: begin
                ctr_n   = sync_in ? '0 : CW'(1);
                state_n = sync_in ? IDLE : START;
            end
            START: begin
                if (sync_in) begin
                    state_n = IDLE;
                    ctr_n   = '0;
                end else if (ctr == CW'(BITDUR / 2 - 1)) begin
                    state_n = DATA;
                    ctr_n   = '0;
                    idx_n   = '0;
                    ferr_n  = 1'b0;
                end
            end
            DATA: if (mid) begin
                shift_n = {sync_in, shift[DATABITS-1:1]};
                idx_n   = idx == IW'(DATABITS - 1) ? '0 : idx + IW'(1);
                state_n = idx != IW'(DATABITS - 1) ? DATA : (PARITY != 0 ? PAR : STOP);
            end
            PAR: if (mid) begin
                par_n   = sync_in;
                state_n = STOP;
            end
            STOP: if (mid) begin
                ferr_n = ferr | ~sync_in;
                idx_n  = idx + IW'(1);
                if (idx == IW'(STOPBITS - 1)) begin
                    idx_n   = '0;
                    data_n  = shift;
                    pe_n    = PARITY == 0 ? 1'b0 : (PARITY == 1 ? (^shift) ^ par_bit : ~((^shift) ^ par_bit));
                    fe_n    = ferr | ~sync_in;
                    ready_n = 1'b1;
                    state_n = sync_in ? IDLE : BRK;
                end
            end
            BRK: begin
                ctr_n   = '0;
                state_n = sync_in ? IDLE : BRK;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
